// File: rtl/dot_i8_seq.sv
// dot_i8_seq: runs a long signed int8 dot product through one k-lane dot unit.
// Each accepted chunk goes through a two-stage pipeline: an operand register
// (p1), then a dot-product register (p2). Every valid p2 stage is added into a
// wide accumulator. The final sum is offered on a valid/ready result port.
module dot_i8_seq #(
    parameter int bit_width  = 8,
    parameter int k          = 32,
    parameter int max_chunks = 16,
    parameter int dp_width   = 2*bit_width + $clog2(k),
    parameter int acc_width  = dp_width + $clog2(max_chunks),
    parameter int len_width  = $clog2(max_chunks+1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [len_width-1:0]        i_len,
    output logic                        o_busy,
    input  logic signed [bit_width-1:0] i_op0 [k],
    input  logic signed [bit_width-1:0] i_op1 [k],
    input  logic                        i_valid,
    output logic                        o_ready,
    output logic signed [acc_width-1:0] o_acc,
    output logic                        o_valid,
    input  logic                        i_ready
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [len_width-1:0]        len_q, len_d;
    logic [len_width-1:0]        cnt_q, cnt_d;
    logic                        ready_q, ready_d;
    logic                        valid_q, valid_d;
    logic                        p1_v_q, p1_v_d;
    logic                        p2_v_q, p2_v_d;
    logic signed [bit_width-1:0] p1_op0_q [k];
    logic signed [bit_width-1:0] p1_op0_d [k];
    logic signed [bit_width-1:0] p1_op1_q [k];
    logic signed [bit_width-1:0] p1_op1_d [k];
    logic signed [dp_width-1:0]  p2_dp_q, p2_dp_d;
    logic signed [acc_width-1:0] acc_q, acc_d;

    logic signed [2*bit_width-1:0] lane_prod [k];
    logic signed [dp_width-1:0]    dot_sum;
    logic                          xfer;
    logic [len_width-1:0]          len_clamped;

    // Combinational k-lane dot product of the p1 operand registers.
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < k; i++) begin
            lane_prod[i] = p1_op0_q[i] * p1_op1_q[i];
            dot_sum = dot_sum +
                {{(dp_width-2*bit_width){lane_prod[i][2*bit_width-1]}}, lane_prod[i]};
        end
    end

    // Next-state logic for the sequencer, pipeline and accumulator.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        p1_op0_d = p1_op0_q;
        p1_op1_d = p1_op1_q;
        p2_dp_d  = p2_dp_q;

        if (i_len > len_width'(max_chunks)) begin
            len_clamped = len_width'(max_chunks);
        end else begin
            len_clamped = i_len;
        end

        // o_ready is registered, so the transfer condition only needs i_valid on top of it.
        xfer   = (state_q == S_RUN) && ready_q && i_valid;
        p1_v_d = xfer;
        if (xfer) begin
            p1_op0_d = i_op0;
            p1_op1_d = i_op1;
        end

        p2_v_d = p1_v_q;
        if (p1_v_q) begin
            p2_dp_d = dot_sum;
        end

        if (p2_v_q) begin
            acc_d = acc_q + {{(acc_width-dp_width){p2_dp_q[dp_width-1]}}, p2_dp_q};
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    len_d   = len_clamped;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = (len_clamped == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q + len_width'(1);
                    if (cnt_q + len_width'(1) == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (p2_v_q && !p1_v_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (valid_q && i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_RUN) && (cnt_d < len_d);
        valid_d = (state_q == S_DONE) && !(valid_q && i_ready);
    end

    // State register; reset abandons any job in flight without producing a result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            p1_v_q  <= 1'b0;
            p2_v_q  <= 1'b0;
            p2_dp_q <= '0;
            acc_q   <= '0;
            for (int i = 0; i < k; i++) begin
                p1_op0_q[i] <= '0;
                p1_op1_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            p1_v_q   <= p1_v_d;
            p2_v_q   <= p2_v_d;
            p2_dp_q  <= p2_dp_d;
            acc_q    <= acc_d;
            p1_op0_q <= p1_op0_d;
            p1_op1_q <= p1_op1_d;
        end
    end

    assign o_busy  = (state_q != S_IDLE);
    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_acc   = acc_q;

endmodule

// File: doc/dot_i8_seq.md
Name: dot_i8_seq

Overview:
Sequencer and accumulator that runs a long signed int8 dot product through one k-lane dot_i8 datapath, one k-element chunk per beat. A job is started with a chunk count; the block accepts chunks over a valid/ready handshake, pipelines each through the dot unit, and sums the partial products. It presents the final sum on a valid/ready result port. It sits between the operand fetch and the MX scaling/output stage.

Parameters:
bit_width, 8, element width in bits (signed two's complement).
k, 32, lanes per chunk; this is the dot_i8 vector length.
max_chunks, 16, maximum chunks per job.
dp_width, 2*bit_width+$clog2(k), width of the dot_i8 result.
acc_width, dp_width+$clog2(max_chunks), width of the accumulator and result.
len_width, $clog2(max_chunks+1), width of the chunk-count input.

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_start  in  1  job start request; sampled only in IDLE.
i_len  in  len_width  chunk count for the job; latched on the accepted start.
o_busy  out  1  high in every state except IDLE.
i_op0  in  signed [bit_width-1:0] x k  chunk operand A.
i_op1  in  signed [bit_width-1:0] x k  chunk operand B.
i_valid  in  1  chunk valid.
o_ready  out  1  chunk ready.
o_acc  out  signed acc_width  job result.
o_valid  out  1  result valid.
i_ready  in  1  result consumer ready.

Behaviour:
- Reset (asynchronous, while i_rst_n=0):
  - FSM goes to IDLE.
  - Chunk counter, pipeline valid bits, p1 operand registers, p2 dp register and accumulator all clear to 0.
  - o_busy=0, o_ready=0, o_valid=0, o_acc=0.
  - Reset mid-job discards the job with no result; the first edge after release is IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - i_start=1 latches len = min(i_len, max_chunks), clears the accumulator and counter.
  - Next state is RUN if len>0; if len=0, next state is DONE with o_acc=0.
- RUN:
  - o_ready=1 while accepted<len.
  - A transfer occurs on i_valid&&o_ready; it loads p1_op0/p1_op1 and sets p1_v.
  - Edge after the transfer: p2_dp <= dot_i8(p1), p2_v <= p1_v.
  - Following edge: if p2_v, acc <= acc + sign-extended p2_dp.
  - The edge completing the len-th transfer moves the FSM to DRAIN; o_ready is 0 from then on.
  - Bubbles (i_valid=0) are allowed; invalid stages never touch acc.
- DRAIN:
  - o_ready=0.
  - Move to DONE on the edge where the last valid p2 stage is accumulated; p1_v and p2_v are both 0 afterwards.
- DONE:
  - o_valid=1; o_acc holds the final sum, stable while o_valid=1 && i_ready=0.
  - On o_valid&&i_ready, next state is IDLE and o_valid drops on that edge.
- Latency:
  - Last transfer at edge E -> accumulate at E+2 -> o_valid=1 after E+3.
  - Back-to-back job of L chunks, start at edge S: transfers at S+1..S+L, o_valid high after edge S+L+3.
- Arithmetic:
  - All signed.
  - acc_width covers max_chunks * k * (-2^(bit_width-1))^2, so no overflow or wrap is possible.
  - No saturation logic.
- Ignored inputs:
  - i_start outside IDLE is ignored; the current job is unaffected.
  - i_valid outside RUN is ignored, and no transfer occurs.
  - i_len changes after the start are ignored.
- Control outputs (o_ready, o_valid, o_busy) are decoded from registered state only, with no combinational path from i_valid/i_ready.
- Next job: the completing edge IDLE->... allows i_start on the first IDLE cycle, giving a minimum 1 IDLE cycle between jobs.

Test Plan:
1. Reset, start len=1; chunk with all op0=1, op1=1, k=32 -> o_valid 3 cycles after transfer, o_acc=32.
2. len=16; every chunk has all op0=-128, op1=-128, back-to-back -> o_acc=16*32*16384=8388608, no overflow; o_ready high for exactly 16 transfer cycles.
3. len=4; chunk dot values 10, -20, 30, -5, with i_valid bubbles of 0, 2, 1 cycles between chunks -> o_acc=15; the pipeline never accumulates a bubble.
4. Result hold: o_valid=1 with i_ready=0 for 5 cycles -> o_acc stable; i_start pulses during DONE ignored; i_ready=1 -> IDLE next cycle, o_valid=0.
5. len=0 -> DONE next cycle, o_acc=0, no chunk accepted. len=20 -> clamped to 16 transfers.
6. Assert i_rst_n=0 mid-RUN after 2 of 8 chunks -> all outputs 0 immediately. New start len=1 with a chunk of dot 7 -> o_acc=7, no stale partial sum.
